// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The slave side is the subtractor itself; the master side is whoever feeds and drains it.
interface serial_subtractor_if #(parameter int WIDTH = 8);
   logic             io_in_valid;
   logic             io_in_ready;
   logic [WIDTH-1:0] io_in_a;
   logic [WIDTH-1:0] io_in_b;
   logic             io_out_valid;
   logic             io_out_ready;
   logic [WIDTH-1:0] io_out_diff;
   logic             io_out_borrow;

   modport master (
      output io_in_valid, io_in_a, io_in_b, io_out_ready,
      input  io_in_ready, io_out_valid, io_out_diff, io_out_borrow
   );

   modport slave (
      input  io_in_valid, io_in_a, io_in_b, io_out_ready,
      output io_in_ready, io_out_valid, io_out_diff, io_out_borrow
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b, one bit per cycle LSB first, through a registered
// borrow. Trades latency (WIDTH cycles) for a single full-subtractor cell.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input logic                clock,
   input logic                reset,
   serial_subtractor_if.slave io
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] aReg_q, aReg_d;
   logic [WIDTH-1:0] bReg_q, bReg_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic             outBorrow_q, outBorrow_d;
   logic [CW-1:0]    count_q, count_d;

   logic             diffBit;
   logic             borrowNext;
   logic [WIDTH:0]   shifted;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         aReg_q      <= '0;
         bReg_q      <= '0;
         result_q    <= '0;
         diff_q      <= '0;
         borrow_q    <= 1'b0;
         outBorrow_q <= 1'b0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         aReg_q      <= aReg_d;
         bReg_q      <= bReg_d;
         result_q    <= result_d;
         diff_q      <= diff_d;
         borrow_q    <= borrow_d;
         outBorrow_q <= outBorrow_d;
         count_q     <= count_d;
      end
   end

   // The published diff/borrow live in their own registers so they only change when a
   // new result completes, and hold through IDLE and the next RUN.
   always_comb begin
      state_d     = state_q;
      aReg_d      = aReg_q;
      bReg_d      = bReg_q;
      result_d    = result_q;
      diff_d      = diff_q;
      borrow_d    = borrow_q;
      outBorrow_d = outBorrow_q;
      count_d     = count_q;

      diffBit    = aReg_q[0] ^ bReg_q[0] ^ borrow_q;
      borrowNext = (~aReg_q[0] & bReg_q[0]) | (~(aReg_q[0] ^ bReg_q[0]) & borrow_q);
      shifted    = {diffBit, result_q};

      unique case (state_q)
         IDLE: begin
            if (io.io_in_valid) begin
               aReg_d   = io.io_in_a;
               bReg_d   = io.io_in_b;
               borrow_d = 1'b0;
               count_d  = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            aReg_d   = aReg_q >> 1;
            bReg_d   = bReg_q >> 1;
            result_d = shifted[WIDTH:1];
            borrow_d = borrowNext;
            count_d  = count_q + 1'b1;
            if (count_q == CW'(WIDTH - 1)) begin
               diff_d      = shifted[WIDTH:1];
               outBorrow_d = borrowNext;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (io.io_out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign io.io_in_ready   = (state_q == IDLE);
   assign io.io_out_valid  = (state_q == DONE);
   assign io.io_out_diff   = diff_q;
   assign io.io_out_borrow = outBorrow_q;

endmodule
